bp_update_sched: RTL and testbench
==================================

Name: bp_update_sched

Overview:
- Sequences all writes into the dual-issue branch predictor's BHT/PHT.
- Accepts up to two resolved-branch updates per cycle from the E-stage master/slave slots and buffers them in a small FIFO. Drains them one per cycle through the predictor's single update port under a ready handshake.
- After reset, runs a table-clear sweep before normal updates are allowed.
- Sits between the E stage and the predictor tables.

Parameters:
- BHT_DEPTH, 10, log2 of BHT entries; update index width.
- FIFO_DEPTH, 4, update queue entries; power of two, ≥2.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stallE  in  1  E stage stalled; no enqueue.
- flushE  in  1  E stage flushed; no enqueue.
- branch1E  in  1  master slot holds a resolved conditional branch.
- branch2E  in  1  slave slot holds a resolved conditional branch.
- pcE  in  32  master slot PC.
- PcPlus4E  in  32  slave slot PC.
- actual_take1E  in  1  master branch outcome.
- actual_take2E  in  1  slave branch outcome.
- upd_ready  in  1  predictor accepts an update this cycle.
- upd_valid  out  1  update or clear command valid.
- upd_clear  out  1  command is a table clear (write zero), not a history update.
- upd_index  out  BHT_DEPTH  table index.
- upd_take  out  1  outcome to shift into history / train the PHT; 0 when upd_clear.
- init_done  out  1  clear sweep finished.
- fifo_count  out  log2(FIFO_DEPTH)+1  occupied entries.
- drop_cnt  out  DROP_W  updates discarded since reset.

Behaviour:
- Single clock domain.
- Reset (rst=1 at posedge), next-cycle values:
  - state=INIT, clear counter=0, FIFO empty, fifo_count=0, drop_cnt=0, init_done=0.
  - upd_valid=1, upd_clear=1, upd_index=0: the sweep starts immediately after reset.
  - rst asserted mid-sweep or mid-run restarts the sweep at index 0 and empties the FIFO.
- State INIT:
  - Each cycle: upd_valid=1, upd_clear=1, upd_index=counter, upd_take=0. upd_ready is ignored, so the predictor must accept clears unconditionally.
  - Counter increments by 1. At counter=2^BHT_DEPTH−1 the next state is RUN and init_done becomes 1.
  - The sweep lasts exactly 2^BHT_DEPTH cycles.
  - Branch updates arriving in INIT are not enqueued. Each one counts as dropped.
- State RUN:
  - init_done=1 and upd_clear=0.
  - upd_valid=~empty; upd_index/upd_take come from the FIFO head.
  - Head pops when upd_valid & upd_ready. upd_index and upd_take must hold while upd_valid & ~upd_ready.
  - RUN is left only by reset.
- Enqueue qualification: slot k is a request when branchkE & ~stallE & ~flushE.
  - Slot1 index = pcE[BHT_DEPTH+1:2], take = actual_take1E.
  - Slot2 index = PcPlus4E[BHT_DEPTH+1:2], take = actual_take2E. Each slot uses its own outcome.
- Ordering:
  - When both slots request in the same cycle, slot1 is written before slot2, so slot1 is dequeued first.
  - FIFO order is strictly program order.
- Capacity: free = FIFO_DEPTH − fifo_count + pop, where pop is a same-cycle dequeue.
  - Both slots request, free≥2: both enqueued.
  - Both slots request, free=1: slot1 enqueued, slot2 dropped.
  - free=0: all requests dropped.
  - Only slot2 requests and free≥1: slot2 takes the first free position.
- Latency:
  - An entry enqueued at edge N is visible at the head from cycle N+1 if the FIFO was empty.
  - No combinational path from the branch*E inputs to the upd_* outputs.
- fifo_count next value = count + enqueued − popped, range 0..FIFO_DEPTH.
- drop_cnt adds the number dropped this cycle (0–2) and saturates at 2^DROP_W−1.
- Read/write pointers wrap modulo FIFO_DEPTH. Full versus empty is distinguished by fifo_count.
- Simultaneous pop and 2 enqueues when full: the pop frees one slot. slot1 is accepted, slot2 is dropped, and fifo_count stays FIFO_DEPTH.

Test Plan:
- Reset sweep (BHT_DEPTH=4): release rst → 16 cycles with upd_valid=1, upd_clear=1, upd_index 0..15; init_done=1 from cycle 17; upd_valid=0 with FIFO empty.
- Dual enqueue order: RUN, upd_ready=1, branch1E=branch2E=1, pcE=0x100 take1=1, PcPlus4E=0x104 take2=0 → upd_index=0x40 take=1 next cycle, then 0x41 take=0; fifo_count 2→1→0.
- Backpressure/overflow (FIFO_DEPTH=4): upd_ready=0, 3 dual-branch cycles → fifo_count=4, drop_cnt=2, upd_index held stable across all cycles.
- Full with pop: FIFO full, upd_ready=1, both slots request → slot1 accepted, slot2 dropped, fifo_count=4, drop_cnt+1.
- Gating: branch1E=1 with stallE=1, then with flushE=1 → no enqueue, drop_cnt unchanged. Branch during INIT → drop_cnt=1, nothing is issued after init.
- Reset mid-run: FIFO holding 3 entries, pulse rst → fifo_count=0, init_done=0, sweep restarts at index 0.

Source files
------------

// File: rtl/bp_update_sched_if.sv
// Update port between the scheduler and the BHT/PHT.
// The scheduler drives the command fields; the predictor returns upd_ready.
interface bp_update_sched_if #(
  parameter int BHT_DEPTH = 10
) ();
  logic                 upd_valid;
  logic                 upd_clear;
  logic [BHT_DEPTH-1:0] upd_index;
  logic                 upd_take;
  logic                 upd_ready;

  modport master (
    output upd_valid,
    output upd_clear,
    output upd_index,
    output upd_take,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_clear,
    input  upd_index,
    input  upd_take,
    output upd_ready
  );
endinterface

// File: rtl/bp_update_sched.sv
// Orders BHT/PHT writes: a post-reset clear sweep, then resolved-branch updates from
// both E-stage slots, queued in program order and drained one per cycle.
module bp_update_sched #(
  parameter int BHT_DEPTH  = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stallE,
  input  logic                          flushE,
  input  logic                          branch1E,
  input  logic                          branch2E,
  input  logic [31:0]                   pcE,
  input  logic [31:0]                   PcPlus4E,
  input  logic                          actual_take1E,
  input  logic                          actual_take2E,
  bp_update_sched_if.master             upd,
  output logic                          init_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [DROP_W-1:0]             drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BHT_DEPTH-1:0] r_clr_cnt;

  logic [BHT_DEPTH-1:0] r_idx_mem  [FIFO_DEPTH];
  logic                 r_take_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic [DROP_W-1:0]    r_drop;

  logic                 w_run;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_req1;
  logic                 w_req2;
  logic                 w_acc1;
  logic                 w_acc2;
  logic [CW-1:0]        w_free;
  logic [1:0]           w_num_req;
  logic [1:0]           w_num_enq;
  logic [1:0]           w_num_drop;
  logic [PW-1:0]        w_wptr2;
  logic [DROP_W:0]      w_drop_sum;
  logic [BHT_DEPTH-1:0] w_idx1;
  logic [BHT_DEPTH-1:0] w_idx2;
  logic                 w_unused;

  assign w_idx1   = pcE[BHT_DEPTH+1:2];
  assign w_idx2   = PcPlus4E[BHT_DEPTH+1:2];
  assign w_unused = ^{pcE[31:BHT_DEPTH+2], pcE[1:0], PcPlus4E[31:BHT_DEPTH+2], PcPlus4E[1:0]};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_INIT;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_run         = 1'b0;
    upd.upd_valid = 1'b0;
    upd.upd_clear = 1'b0;
    upd.upd_index = '0;
    upd.upd_take  = 1'b0;
    case (r_state)
      S_INIT: begin
        // Clears are unconditional: the predictor must take one every cycle.
        upd.upd_valid = 1'b1;
        upd.upd_clear = 1'b1;
        upd.upd_index = r_clr_cnt;
        if (&r_clr_cnt) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_run         = 1'b1;
        upd.upd_valid = ~w_empty;
        upd.upd_index = r_idx_mem[r_rptr];
        upd.upd_take  = r_take_mem[r_rptr];
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  assign init_done = (r_state == S_RUN);

  // ---------------------------------------------------------- queue control
  assign w_empty = (r_count == '0);
  assign w_pop   = w_run & ~w_empty & upd.upd_ready;
  assign w_req1  = branch1E & ~stallE & ~flushE;
  assign w_req2  = branch2E & ~stallE & ~flushE;

  // A same-cycle pop frees its slot for this cycle's writes.
  assign w_free  = CW'(FIFO_DEPTH) - r_count + CW'(w_pop);
  assign w_acc1  = w_run & w_req1 & (w_free != '0);
  assign w_acc2  = w_run & w_req2 & (w_acc1 ? (w_free >= CW'(2)) : (w_free != '0));

  assign w_num_req  = {1'b0, w_req1} + {1'b0, w_req2};
  assign w_num_enq  = {1'b0, w_acc1} + {1'b0, w_acc2};
  assign w_num_drop = w_num_req - w_num_enq;
  assign w_wptr2    = r_wptr + PW'(w_acc1);
  assign w_drop_sum = {1'b0, r_drop} + (DROP_W+1)'(w_num_drop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= '0;
    end else begin
      r_wptr  <= r_wptr + PW'(w_num_enq);
      r_rptr  <= r_rptr + PW'(w_pop);
      r_count <= r_count + CW'(w_num_enq) - CW'(w_pop);
      r_drop  <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
    end
  end

  // Slot1 lands at the write pointer; slot2 behind it, or there if slot1 was absent.
  always_ff @(posedge clk) begin
    if (w_acc1) begin
      r_idx_mem[r_wptr]  <= w_idx1;
      r_take_mem[r_wptr] <= actual_take1E;
    end
    if (w_acc2) begin
      r_idx_mem[w_wptr2]  <= w_idx2;
      r_take_mem[w_wptr2] <= actual_take2E;
    end
  end

  assign fifo_count = r_count;
  assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_bp_update_sched.sv
// Bench for bp_update_sched: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the scheduling rules.
module tb_bp_update_sched;

  localparam int BHT = 4;
  localparam int FD  = 4;
  localparam int DW  = 4;
  localparam int SWEEP    = 1 << BHT;
  localparam int DROP_MAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          stallE, flushE, branch1E, branch2E;
  logic [31:0]   pcE, PcPlus4E;
  logic          actual_take1E, actual_take2E;
  logic          init_done;
  logic [2:0]    fifo_count;
  logic [DW-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  bp_update_sched_if #(.BHT_DEPTH(BHT)) upd ();

  bp_update_sched #(
    .BHT_DEPTH (BHT),
    .FIFO_DEPTH(FD),
    .DROP_W    (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallE       (stallE),
    .flushE       (flushE),
    .branch1E     (branch1E),
    .branch2E     (branch2E),
    .pcE          (pcE),
    .PcPlus4E     (PcPlus4E),
    .actual_take1E(actual_take1E),
    .actual_take2E(actual_take2E),
    .upd          (upd.master),
    .init_done    (init_done),
    .fifo_count   (fifo_count),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------ reference model
  int m_init_left = 0;
  int m_clr       = 0;
  int m_drop      = 0;
  int q_idx[$];
  bit q_take[$];

  function automatic int pc_index(input logic [31:0] pc);
    return int'(pc / 4) % SWEEP;
  endfunction

  function automatic void model_edge();
    int n;
    bit r1, r2;
    r1 = branch1E && !stallE && !flushE;
    r2 = branch2E && !stallE && !flushE;
    n  = 0;
    if (rst) begin
      m_init_left = SWEEP;
      m_clr       = 0;
      m_drop      = 0;
      q_idx.delete();
      q_take.delete();
      return;
    end
    if (m_init_left > 0) begin
      n = int'(r1) + int'(r2);
      m_clr++;
      m_init_left--;
    end else begin
      if (q_idx.size() > 0 && upd.upd_ready) begin
        void'(q_idx.pop_front());
        void'(q_take.pop_front());
      end
      if (r1) begin
        if (q_idx.size() < FD) begin
          q_idx.push_back(pc_index(pcE));
          q_take.push_back(actual_take1E);
        end else n++;
      end
      if (r2) begin
        if (q_idx.size() < FD) begin
          q_idx.push_back(pc_index(PcPlus4E));
          q_take.push_back(actual_take2E);
        end else n++;
      end
    end
    m_drop = (m_drop + n > DROP_MAX) ? DROP_MAX : m_drop + n;
  endfunction

  function automatic bit m_valid();
    return (m_init_left > 0) || (q_idx.size() > 0);
  endfunction
  function automatic bit m_clear();
    return m_init_left > 0;
  endfunction
  function automatic int m_index();
    if (m_init_left > 0) return m_clr;
    return (q_idx.size() > 0) ? q_idx[0] : 0;
  endfunction
  function automatic bit m_take();
    if (m_init_left > 0 || q_take.size() == 0) return 1'b0;
    return q_take[0];
  endfunction
  function automatic int m_count();
    return (m_init_left > 0) ? 0 : q_idx.size();
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stallE = 0; flushE = 0; branch1E = 0; branch2E = 0;
    pcE = '0; PcPlus4E = '0; actual_take1E = 0; actual_take2E = 0;
  endtask

  // ------------------------------------------------------------- scenarios
  task automatic test_reset();
    idle_inputs();
    upd.upd_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %0b exp 0", init_done); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
    for (int i = 0; i < SWEEP; i++) begin
      checks++;
      if (upd.upd_valid !== 1'b1 || upd.upd_clear !== 1'b1 || upd.upd_index !== BHT'(i) || upd.upd_take !== 1'b0) begin
        errors++;
        $display("FAIL sweep_%0d got v%0b c%0b idx%0d t%0b exp v1 c1 idx%0d t0",
                 i, upd.upd_valid, upd.upd_clear, upd.upd_index, upd.upd_take, i);
      end
      step();
    end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL sweep_done got %0b exp 1", init_done); end
    checks++; if (upd.upd_valid !== 1'b0 || upd.upd_clear !== 1'b0) begin
      errors++; $display("FAIL run_idle got v%0b c%0b exp v0 c0", upd.upd_valid, upd.upd_clear); end
  endtask

  task automatic test_dual_order();
    upd.upd_ready = 1'b1;
    branch1E = 1; branch2E = 1;
    pcE = 32'h100; actual_take1E = 1;
    PcPlus4E = 32'h104; actual_take2E = 0;
    step();
    idle_inputs();
    checks++;
    if (upd.upd_valid !== 1'b1 || upd.upd_index !== BHT'(pc_index(32'h100)) || upd.upd_take !== 1'b1 || fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL dual_first got v%0b idx%0d t%0b cnt%0d exp v1 idx%0d t1 cnt2",
               upd.upd_valid, upd.upd_index, upd.upd_take, fifo_count, pc_index(32'h100));
    end
    step();
    checks++;
    if (upd.upd_valid !== 1'b1 || upd.upd_index !== BHT'(pc_index(32'h104)) || upd.upd_take !== 1'b0 || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL dual_second got v%0b idx%0d t%0b cnt%0d exp v1 idx%0d t0 cnt1",
               upd.upd_valid, upd.upd_index, upd.upd_take, fifo_count, pc_index(32'h104));
    end
    step();
    checks++;
    if (upd.upd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL dual_drained got v%0b cnt%0d exp v0 cnt0", upd.upd_valid, fifo_count);
    end
  endtask

  task automatic test_backpressure();
    int exp_cnt[3]  = '{2, 4, 4};
    int exp_drop[3] = '{0, 0, 2};
    upd.upd_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      branch1E = 1; branch2E = 1;
      pcE = 32'h20 + 32'(c * 8); actual_take1E = 1;
      PcPlus4E = 32'h24 + 32'(c * 8); actual_take2E = 0;
      step();
      checks++;
      if (fifo_count !== 3'(exp_cnt[c]) || drop_cnt !== DW'(exp_drop[c])) begin
        errors++;
        $display("FAIL bp_fill_%0d got cnt%0d drop%0d exp cnt%0d drop%0d",
                 c, fifo_count, drop_cnt, exp_cnt[c], exp_drop[c]);
      end
      checks++;
      if (upd.upd_valid !== 1'b1 || upd.upd_index !== BHT'(8) || upd.upd_take !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d got v%0b idx%0d t%0b exp v1 idx8 t1", c, upd.upd_valid, upd.upd_index, upd.upd_take);
      end
    end
    idle_inputs();
  endtask

  task automatic test_full_pop();
    int exp_idx[4] = '{10, 11, 12, 0};
    upd.upd_ready = 1'b1;
    branch1E = 1; branch2E = 1;
    pcE = 32'h70; actual_take1E = 1;
    PcPlus4E = 32'h74; actual_take2E = 1;
    step();
    idle_inputs();
    checks++;
    if (fifo_count !== 3'd4 || drop_cnt !== DW'(3) || upd.upd_index !== BHT'(9) || upd.upd_take !== 1'b0) begin
      errors++;
      $display("FAIL full_pop got cnt%0d drop%0d idx%0d t%0b exp cnt4 drop3 idx9 t0",
               fifo_count, drop_cnt, upd.upd_index, upd.upd_take);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (fifo_count !== 3'(3 - k) || (k < 3 && upd.upd_index !== BHT'(exp_idx[k]))) begin
        errors++;
        $display("FAIL drain_%0d got cnt%0d idx%0d exp cnt%0d idx%0d", k, fifo_count, upd.upd_index, 3 - k, exp_idx[k]);
      end
    end
  endtask

  task automatic test_gating();
    upd.upd_ready = 1'b1;
    branch1E = 1; branch2E = 1; pcE = 32'h10; PcPlus4E = 32'h14;
    stallE = 1;
    step();
    checks++;
    if (fifo_count !== 3'd0 || upd.upd_valid !== 1'b0 || drop_cnt !== DW'(3)) begin
      errors++; $display("FAIL gate_stall got cnt%0d v%0b drop%0d exp cnt0 v0 drop3", fifo_count, upd.upd_valid, drop_cnt);
    end
    stallE = 0; flushE = 1;
    step();
    checks++;
    if (fifo_count !== 3'd0 || upd.upd_valid !== 1'b0 || drop_cnt !== DW'(3)) begin
      errors++; $display("FAIL gate_flush got cnt%0d v%0b drop%0d exp cnt0 v0 drop3", fifo_count, upd.upd_valid, drop_cnt);
    end
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    branch1E = 1; pcE = 32'h3c; actual_take1E = 1;
    step();
    idle_inputs();
    for (int i = 0; i < SWEEP - 2; i++) step();
    checks++;
    if (init_done !== 1'b1 || drop_cnt !== DW'(1) || upd.upd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL init_drop got done%0b drop%0d v%0b cnt%0d exp done1 drop1 v0 cnt0",
               init_done, drop_cnt, upd.upd_valid, fifo_count);
    end
  endtask

  task automatic test_reset_midrun();
    upd.upd_ready = 1'b0;
    branch1E = 1; branch2E = 1; pcE = 32'h30; PcPlus4E = 32'h34;
    step();
    branch2E = 0; pcE = 32'h38;
    step();
    idle_inputs();
    checks++;
    if (fifo_count !== 3'd3) begin errors++; $display("FAIL midrun_fill got cnt%0d exp 3", fifo_count); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (fifo_count !== 3'd0 || init_done !== 1'b0 || upd.upd_valid !== 1'b1 || upd.upd_clear !== 1'b1 || upd.upd_index !== '0) begin
      errors++;
      $display("FAIL midrun_reset got cnt%0d done%0b v%0b c%0b idx%0d exp cnt0 done0 v1 c1 idx0",
               fifo_count, init_done, upd.upd_valid, upd.upd_clear, upd.upd_index);
    end
    step();
    checks++;
    if (upd.upd_index !== BHT'(1) || upd.upd_clear !== 1'b1) begin
      errors++; $display("FAIL midrun_sweep got idx%0d c%0b exp idx1 c1", upd.upd_index, upd.upd_clear);
    end
    for (int i = 0; i < SWEEP - 1; i++) step();
    checks++;
    if (init_done !== 1'b1 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL midrun_done got done%0b cnt%0d exp done1 cnt0", init_done, fifo_count);
    end
  endtask

  task automatic test_random();
    int shown = 0;
    for (int n = 0; n < 3000; n++) begin
      bit bad;
      bad = 1'b0;
      checks++;
      if (upd.upd_valid !== m_valid() || upd.upd_clear !== m_clear() || init_done !== !m_clear() ||
          fifo_count !== 3'(m_count()) || drop_cnt !== DW'(m_drop)) bad = 1'b1;
      if (m_valid() && (upd.upd_index !== BHT'(m_index()) || upd.upd_take !== m_take())) bad = 1'b1;
      if (bad) begin
        errors++;
        if (shown < 20) begin
          shown++;
          $display("FAIL rand_%0d got v%0b c%0b idx%0d t%0b done%0b cnt%0d drop%0d exp v%0b c%0b idx%0d t%0b done%0b cnt%0d drop%0d",
                   n, upd.upd_valid, upd.upd_clear, upd.upd_index, upd.upd_take, init_done, fifo_count, drop_cnt,
                   m_valid(), m_clear(), m_index(), m_take(), !m_clear(), m_count(), m_drop);
        end
      end
      rst           = ($urandom_range(0, 499) == 0);
      stallE        = ($urandom_range(0, 7) == 0);
      flushE        = ($urandom_range(0, 7) == 0);
      branch1E      = $urandom_range(0, 1);
      branch2E      = $urandom_range(0, 1);
      pcE           = $urandom;
      PcPlus4E      = $urandom;
      actual_take1E = $urandom_range(0, 1);
      actual_take2E = $urandom_range(0, 1);
      upd.upd_ready = ($urandom_range(0, 99) < ((n < 1500) ? 30 : 75));
      step();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    upd.upd_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_dual_order();
    test_backpressure();
    test_full_pop();
    test_gating();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
